fifo_ram_ctrl_e2: RTL
=====================

Name: fifo_ram_ctrl_e2

Overview:
Parametrised FIFO that wraps its own RAM storage. It owns the write and read pointers, the occupancy count and the status flags, and registers read data. It is the next-generation queue primitive for the device datapath and replaces the external-pointer RAM plus separate control. It adds programmable almost-full/almost-empty thresholds, a read-valid strobe, defined full/empty collision rules and sticky overflow/underflow errors.

Parameters:
DATA_SIZE, 10, width of each stored word in bits.
ADDR_SIZE, 3, pointer width; DEPTH = 2**ADDR_SIZE entries (default 8).

Ports:
clk  input  1  single clock; all state updates on posedge.
reset_L  input  1  asynchronous active-low reset.
write  input  1  push request.
read  input  1  pop request.
data_in  input  DATA_SIZE  word to push.
af_thresh  input  ADDR_SIZE+1  almost-full threshold; legal range 1..DEPTH.
ae_thresh  input  ADDR_SIZE+1  almost-empty threshold; legal range 0..DEPTH-1.
err_clr  input  1  synchronous clear of the sticky error flags.
data_out  output  DATA_SIZE  registered read data.
valid_out  output  1  data_out carries a newly popped word this cycle.
count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
almost_empty  output  1  count <= ae_thresh.
almost_full  output  1  count >= af_thresh.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (reset_L=0, asynchronous, takes effect without a clock edge):
  - wr_ptr, rd_ptr and count = 0.
  - data_out = 0, valid_out = 0, overflow = 0, underflow = 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0 for any legal af_thresh.
  - RAM contents are not reset. Stale entries are unreachable because the pointers are cleared.
- Reset asserted mid-operation discards all queued data. Any in-flight read does not produce valid_out.
- Flags are combinational decodes of the registered count, so they change the cycle after the accepting edge.
- Accept rules, evaluated on the current (pre-edge) count:
  - rd_acc = read & ~empty.
  - wr_acc = write & (~full | rd_acc). A simultaneous read and write while full are both accepted and count stays at DEPTH.
  - Read and write on empty: the write is accepted, the read is rejected, underflow is set, and count goes to 1. There is no fall-through.
- Write: when wr_acc, ram[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Read:
  - When rd_acc, data_out <= ram[rd_ptr], rd_ptr <= rd_ptr+1 (wrapping modulo DEPTH), and valid_out <= 1 for exactly one cycle. Read latency is 1 clock.
  - Without rd_acc, valid_out <= 0 and data_out holds its last value.
- Read/write same address: only possible when full with simultaneous read and write. Old data is read (read-before-write).
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged for both or neither. It never exceeds DEPTH or goes below 0.
- Errors:
  - overflow <= 1 when write & ~wr_acc.
  - underflow <= 1 when read & ~rd_acc.
  - err_clr clears both flags on the next edge. A new error event in the same cycle as err_clr wins and the flag stays 1.
- Illegal thresholds (outside the legal range) produce defined but unspecified flag values. No other state is affected.

Test Plan:
- Reset release, af_thresh=6, ae_thresh=2 -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, valid_out=0.
- Write 0x001..0x008 on 8 consecutive cycles -> count steps 1..8; almost_empty drops at count=3; almost_full rises at count=6; full=1 at count=8.
- When full, write 0x3FF alone -> overflow=1, count stays 8, no entry overwritten. Then read+write 0x155 together -> count stays 8, data_out=0x001 with valid_out=1 one cycle later.
- Drain 8 reads back-to-back -> data_out = 0x002..0x008 then 0x155, valid_out high each following cycle. A 9th read gives underflow=1, valid_out=0, and data_out holds 0x155.
- Wrap-around: 20 interleaved writes/reads with pointers crossing index 7->0 -> output order equals input order and count never exceeds 8.
- Assert reset_L=0 between clock edges while count=5 -> all outputs return to reset values immediately. The next write/read pair returns the new word, not old data. Also: err_clr pulse with no new error -> overflow=0, underflow=0 after one edge.

Source files
------------

// File: rtl/fifo_ram_ctrl_e2_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_ctrl_e2_if
// Brief    : Push/pop, threshold and status bundle for fifo_ram_ctrl_e2.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_ram_ctrl_e2_if #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3
);
  logic                 write;
  logic                 read;
  logic [DATA_SIZE-1:0] data_in;
  logic [ADDR_SIZE:0]   af_thresh;
  logic [ADDR_SIZE:0]   ae_thresh;
  logic                 err_clr;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic [ADDR_SIZE:0]   count;
  logic                 empty;
  logic                 full;
  logic                 almost_empty;
  logic                 almost_full;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output write, read, data_in, af_thresh, ae_thresh, err_clr,
    input  data_out, valid_out, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  write, read, data_in, af_thresh, ae_thresh, err_clr,
    output data_out, valid_out, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ram_ctrl_e2.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_ctrl_e2
// Brief    : Self-contained FIFO with internal RAM, 1-cycle registered read,
//            programmable almost flags and sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_ctrl_e2 #(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  fifo_ram_ctrl_e2_if.slave    bus
);

  localparam int unsigned        c_depth      = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] c_full_count = (ADDR_SIZE+1)'(c_depth);
  localparam logic [ADDR_SIZE:0] c_count_one  = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] c_ptr_one  = ADDR_SIZE'(1);

  logic [DATA_SIZE-1:0] ram_q [c_depth];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == c_full_count);
  assign w_rd_acc = bus.read & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign w_wr_acc = bus.write & (~w_full | w_rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    overflow_d  = overflow_q & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;

    if (w_wr_acc) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end

    if (w_rd_acc) begin
      rd_ptr_d   = rd_ptr_q + c_ptr_one;
      data_out_d = ram_q[rd_ptr_q];
      valid_d    = 1'b1;
    end

    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + c_count_one;
      2'b01:   count_d = count_q - c_count_one;
      default: count_d = count_q;
    endcase

    // A fresh error outranks a concurrent clear.
    if (bus.write & ~w_wr_acc) begin
      overflow_d = 1'b1;
    end
    if (bus.read & ~w_rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately unreset; cleared pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      ram_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire
